// File: rtl/mips_pkg.sv
// Shared constants for the ADD/ADDI-only MIPS core: opcodes, register indices,
// instruction field positions and the fixed 8-word program ROM.
package mips_pkg;

    localparam int DATA_W    = 32;
    localparam int ROM_DEPTH = 8;
    localparam int PC_W      = $clog2(ROM_DEPTH);
    localparam int REG_AW    = 5;
    localparam int IN_W      = 9;
    localparam int LED_W     = 10;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;

    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;
    localparam logic [REG_AW-1:0] REG_IN   = 5'd1;
    localparam logic [REG_AW-1:0] REG_OUT  = 5'd2;

    localparam int OP_LSB  = 26;
    localparam int RS_LSB  = 21;
    localparam int RT_LSB  = 16;
    localparam int RD_LSB  = 11;
    localparam int SH_LSB  = 6;
    localparam int FN_LSB  = 0;
    localparam int IMM_LSB = 0;

    typedef logic [31:0] instr_t;
    typedef instr_t rom_t [ROM_DEPTH];

    // addi r3,r0,3 ; add r4,r1,r1 ; add r2,r4,r3 ; addi r5,r2,-1 ; 4 x NOP
    localparam rom_t ROM_IMAGE = '{
        32'h2003_0003,
        32'h0021_2020,
        32'h0083_1020,
        32'h2045_FFFF,
        32'h0000_0000,
        32'h0000_0000,
        32'h0000_0000,
        32'h0000_0000
    };

    function automatic logic [5:0] f_opcode(input instr_t instr);
        return instr[OP_LSB +: 6];
    endfunction

    function automatic logic [5:0] f_funct(input instr_t instr);
        return instr[FN_LSB +: 6];
    endfunction

    function automatic logic [REG_AW-1:0] f_rs(input instr_t instr);
        return instr[RS_LSB +: REG_AW];
    endfunction

    function automatic logic [REG_AW-1:0] f_rt(input instr_t instr);
        return instr[RT_LSB +: REG_AW];
    endfunction

    function automatic logic [REG_AW-1:0] f_rd(input instr_t instr);
        return instr[RD_LSB +: REG_AW];
    endfunction

    function automatic logic [DATA_W-1:0] f_sext16(input instr_t instr);
        return {{(DATA_W-16){instr[IMM_LSB+15]}}, instr[IMM_LSB +: 16]};
    endfunction

endpackage

// File: rtl/mips_regfile.sv
// 32 x DATA_W register file: r0 is hard zero, r1 mirrors the switch input,
// r2..r31 are storage cleared by the synchronous active-low reset.
module mips_regfile
    import mips_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [IN_W-1:0]   sw_data_i,
    input  logic [REG_AW-1:0] ra_addr_i,
    input  logic [REG_AW-1:0] rb_addr_i,
    output logic [DATA_W-1:0] ra_data_o,
    output logic [DATA_W-1:0] rb_data_o,
    input  logic              we_i,
    input  logic [REG_AW-1:0] wa_i,
    input  logic [DATA_W-1:0] wd_i
);

    logic [DATA_W-1:0] regs_q [2:31];
    logic [DATA_W-1:0] sw_ext_s;

    assign sw_ext_s = {{(DATA_W-IN_W){1'b0}}, sw_data_i};

    // Read port A: r0/r1 are synthesised, never stored
    always_comb begin
        ra_data_o = '0;
        case (ra_addr_i)
            REG_ZERO: ra_data_o = '0;
            REG_IN:   ra_data_o = sw_ext_s;
            default:  ra_data_o = regs_q[ra_addr_i];
        endcase
    end

    // Read port B
    always_comb begin
        rb_data_o = '0;
        case (rb_addr_i)
            REG_ZERO: rb_data_o = '0;
            REG_IN:   rb_data_o = sw_ext_s;
            default:  rb_data_o = regs_q[rb_addr_i];
        endcase
    end

    // Write port; writes to r0/r1 fall outside the storage and are dropped
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int i = 2; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (wa_i >= REG_OUT)) begin
            regs_q[wa_i] <= wd_i;
        end
    end

endmodule

// File: rtl/mips_add_addi_wrap.sv
// MAX10 board wrapper: single-cycle ADD/ADDI core running the ROM program, r2 on LEDR.
// Optional macro LED_PC_DEBUG_EN shows PC[2:0] on LEDR[9:7].
module mips_add_addi_wrap
    import mips_pkg::*;
(
    input  logic             MAX10_CLK1_50,
    input  logic [9:0]       SW,
    output logic [LED_W-1:0] LEDR
);

    logic              rst_n_s;
    logic [PC_W-1:0]   pc_q;
    logic [PC_W-1:0]   pc_d;
    logic [LED_W-1:0]  led_q;
    logic [LED_W-1:0]  led_d;
    instr_t            instr_s;
    logic [DATA_W-1:0] rs_data_s;
    logic [DATA_W-1:0] rt_data_s;
    logic              we_s;
    logic [REG_AW-1:0] wa_s;
    logic [DATA_W-1:0] wd_s;
    logic              unused_shamt_s;

    assign rst_n_s        = SW[9];
    assign instr_s        = ROM_IMAGE[pc_q];
    assign unused_shamt_s = ^instr_s[SH_LSB +: 5];

    mips_regfile u_rf (
        .clk_i     (MAX10_CLK1_50),
        .rst_n_i   (rst_n_s),
        .sw_data_i (SW[IN_W-1:0]),
        .ra_addr_i (f_rs(instr_s)),
        .rb_addr_i (f_rt(instr_s)),
        .ra_data_o (rs_data_s),
        .rb_data_o (rt_data_s),
        .we_i      (we_s),
        .wa_i      (wa_s),
        .wd_i      (wd_s)
    );

    // Decode and ALU; unknown encodings fall through as NOPs
    always_comb begin
        we_s = 1'b0;
        wa_s = REG_ZERO;
        wd_s = '0;
        case (f_opcode(instr_s))
            OP_RTYPE: begin
                if (f_funct(instr_s) == FN_ADD) begin
                    we_s = 1'b1;
                    wa_s = f_rd(instr_s);
                    wd_s = rs_data_s + rt_data_s;
                end else begin
                    we_s = 1'b0;
                end
            end
            OP_ADDI: begin
                we_s = 1'b1;
                wa_s = f_rt(instr_s);
                wd_s = rs_data_s + f_sext16(instr_s);
            end
            default: begin
                we_s = 1'b0;
            end
        endcase
    end

    // Next PC and LED shadow of r2
    always_comb begin
        if (pc_q == PC_W'(ROM_DEPTH-1)) begin
            pc_d = '0;
        end else begin
            pc_d = pc_q + PC_W'(1);
        end
        if (we_s && (wa_s == REG_OUT)) begin
            led_d = wd_s[LED_W-1:0];
        end else begin
            led_d = led_q;
        end
    end

    // PC and LED registers; reset wins over any writeback in the same cycle
    always_ff @(posedge MAX10_CLK1_50) begin
        if (!rst_n_s) begin
            pc_q  <= '0;
            led_q <= '0;
        end else begin
            pc_q  <= pc_d;
            led_q <= led_d;
        end
    end

`ifdef LED_PC_DEBUG_EN
    logic unused_led_s;
    assign unused_led_s = ^led_q[LED_W-1:7];
    assign LEDR = {pc_q[2:0], led_q[6:0]};
`else
    assign LEDR = led_q;
`endif

endmodule

// File: tb/tb_mips_add_addi_wrap.sv
// Scoreboard bench: a program-level model predicts LEDR each cycle; a negedge monitor compares.
module tb_mips_add_addi_wrap;

    logic       clk;
    logic [9:0] SW;
    logic [9:0] LEDR;

    int n_tests = 0;
    int n_fail  = 0;

    logic [9:0] exp_q [$];

    // Architectural model of the four-instruction program
    int unsigned m_pc;
    logic [31:0] m_r2, m_r3, m_r4, m_r5;

    mips_add_addi_wrap dut (
        .MAX10_CLK1_50 (clk),
        .SW            (SW),
        .LEDR          (LEDR)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    function automatic logic [9:0] model_led();
        logic [9:0] v;
`ifdef LED_PC_DEBUG_EN
        v = {m_pc[2:0], m_r2[6:0]};
`else
        v = m_r2[9:0];
`endif
        return v;
    endfunction

    task automatic model_edge(input logic rst_n, input logic [8:0] sw);
        if (!rst_n) begin
            m_pc = 0;
            m_r2 = 0; m_r3 = 0; m_r4 = 0; m_r5 = 0;
        end else begin
            case (m_pc)
                0: m_r3 = 32'd3;
                1: m_r4 = 2 * {23'd0, sw};
                2: m_r2 = m_r4 + m_r3;
                3: m_r5 = m_r2 - 32'd1;
                default: ;
            endcase
            m_pc = (m_pc + 1) % 8;
        end
    endtask

    // Monitor: every cycle the DUT presents LEDR, compare it with the queued prediction
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [9:0] e;
            e = exp_q.pop_front();
            n_tests++;
            if (LEDR !== e) begin
                n_fail++;
                $display("FAIL scoreboard_led t=%0t got=%0d expected=%0d", $time, LEDR, e);
            end
        end
    end

    task automatic run(input logic rst_n, input logic [8:0] sw, input int n);
        for (int i = 0; i < n; i++) begin
            SW = {rst_n, sw};
            @(posedge clk);
            model_edge(rst_n, sw);
            exp_q.push_back(model_led());
            @(negedge clk);
            #1;
        end
    endtask

    task automatic check_led(input string name, input logic [9:0] exp);
        n_tests++;
`ifdef LED_PC_DEBUG_EN
        if (LEDR[6:0] !== exp[6:0]) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d", name, LEDR[6:0], exp[6:0]);
        end
`else
        if (LEDR !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d", name, LEDR, exp);
        end
`endif
    endtask

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d", name, act, exp);
        end
    endtask

    initial begin
        logic [8:0] rsw;
        int         rn;
        SW = 10'd0;
        m_pc = 0; m_r2 = 0; m_r3 = 0; m_r4 = 0; m_r5 = 0;

        run(1'b0, 9'd0, 2);
        check_led("reset_led", 10'd0);
        check_val("reset_pc", 32'(dut.pc_q), 32'd0);

        run(1'b1, 9'd0, 2);
        check_led("led_before_3rd_edge", 10'd0);
        run(1'b1, 9'd0, 1);
        check_led("led_at_3rd_edge", 10'd3);
        run(1'b1, 9'd0, 5);
        check_val("r5_sw0", dut.u_rf.regs_q[5], 32'd2);

        run(1'b1, 9'd2, 8);
        check_led("sw2_within_8", 10'd7);
        run(1'b1, 9'd2, 8);
        check_led("sw2_stable", 10'd7);

        run(1'b1, 9'd0, 100);
        check_led("step_sw0", 10'd3);
        run(1'b1, 9'd4, 100);
        check_led("step_sw4", 10'd11);
        run(1'b1, 9'd3, 100);
        check_led("step_sw3", 10'd9);

        run(1'b1, 9'd511, 16);
        check_led("sw511_trunc", 10'd1);
        check_val("r5_sw511", dut.u_rf.regs_q[5], 32'd1024);

        run(1'b1, 9'd4, 13);
        run(1'b0, 9'd4, 1);
        check_led("midreset_led", 10'd0);
        check_val("midreset_pc", 32'(dut.pc_q), 32'd0);
        run(1'b1, 9'd4, 2);
        check_led("midreset_before_3rd", 10'd0);
        run(1'b1, 9'd4, 1);
        check_led("midreset_3rd_edge", 10'd11);

        for (int k = 0; k < 40; k++) begin
            rsw = 9'($urandom_range(0, 511));
            rn  = int'($urandom_range(1, 20));
            if ($urandom_range(0, 9) == 0) begin
                run(1'b0, rsw, 1);
            end else begin
                run(1'b1, rsw, rn);
            end
        end
        run(1'b1, 9'd100, 16);
        check_led("random_tail_sw100", 10'd203);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
